lsu_mem_interface: RTL and testbench

- Load/store bus stage between the execute/memory pipeline and the data memory port.
- Sends byte loads and stores to a word-addressed request/grant/response data bus.
- Generates byte enables and replicates store data across byte lanes.
- Right-aligns load data into bits [7:0]/[15:0] so the downstream result extender only applies sign or zero extension.

---
 rtl/riscv_lsu_pkg.sv | 6 +
 rtl/lsu_align.sv | 22 ++
 rtl/lsu_mem_interface.sv | 92 +++++++++
 tb/tb_lsu_mem_interface.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared types and constants for the load/store bus stage
package riscv_lsu_pkg;
  localparam int BeBits = 4;
  typedef enum logic [1:0] {SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10} size_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: alignment check, byte enables, store lane replication and load right-alignment
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic              misaligned,
  output logic [BeBits-1:0] be,
  output logic [31:0]       wdata_rep,
  output logic [31:0]       rdata_al
);
  logic [31:0] sh;
  always_comb begin
    misaligned = size == SIZE_WORD ? off != 2'b00 : size == SIZE_HALF ? off[0] : size != SIZE_BYTE;
    be = size == SIZE_BYTE ? 4'b0001 << off : size == SIZE_HALF ? 4'b0011 << off : 4'b1111;
    wdata_rep = size == SIZE_BYTE ? {4{wdata[7:0]}} : size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
    sh = rdata >> {off, 3'b000};
    rdata_al = size == SIZE_BYTE ? {24'h0, sh[7:0]} : size == SIZE_HALF ? {16'h0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_mem_interface.sv
// lsu_mem_interface: single-outstanding load/store stage between pipeline and word-addressed data bus
module lsu_mem_interface
  import riscv_lsu_pkg::*;
#(
  parameter int RegBits  = 32,
  parameter int AddrBits = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  input  logic                we_i,
  input  logic [1:0]          size_i,
  input  logic [AddrBits-1:0] addr_i,
  input  logic [RegBits-1:0]  wdata_i,
  output logic                stall_o,
  output logic                done_o,
  output logic                misaligned_o,
  output logic [RegBits-1:0]  rdata_o,
  output logic                data_req_o,
  output logic                data_we_o,
  output logic [BeBits-1:0]   data_be_o,
  output logic [AddrBits-1:0] data_addr_o,
  output logic [RegBits-1:0]  data_wdata_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic [RegBits-1:0]  data_rdata_i
);
  lsu_state_e state, state_n;
  logic                we_q, mis_q, mis, idle;
  logic [1:0]          size_q, off_q, a_size, a_off;
  logic [AddrBits-1:0] addr_q;
  logic [BeBits-1:0]   be_q, be;
  logic [RegBits-1:0]  wdata_q, rdata_q, wrep, ral;

  assign idle   = state == IDLE;
  // One aligner serves both: live inputs while idle, captured access afterwards
  assign a_size = idle ? size_i : size_q;
  assign a_off  = idle ? addr_i[1:0] : off_q;

  lsu_align u_align (
    .size(a_size), .off(a_off), .wdata(wdata_i), .rdata(data_rdata_i),
    .misaligned(mis), .be(be), .wdata_rep(wrep), .rdata_al(ral)
  );

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = idle ? (valid_i ? (mis ? DONE : REQ) : IDLE) :
              state == REQ  ? (data_gnt_i ? WAIT : REQ) :
              state == WAIT ? (data_rvalid_i ? DONE : WAIT) : IDLE;
  end

  always_comb begin
    stall_o      = (idle & valid_i) | state == REQ | state == WAIT;
    done_o       = state == DONE;
    misaligned_o = state == DONE & mis_q;
    data_req_o   = state == REQ;
    data_we_o    = we_q;
    data_be_o    = be_q;
    data_addr_o  = addr_q;
    data_wdata_o = wdata_q;
    rdata_o      = rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (idle && valid_i) begin
        mis_q <= mis;
        if (mis) rdata_q <= '0;
        else begin
          we_q    <= we_i;
          size_q  <= size_i;
          off_q   <= addr_i[1:0];
          addr_q  <= {addr_i[AddrBits-1:2], 2'b00};
          be_q    <= be;
          wdata_q <= wrep;
        end
      end
      if (state == WAIT && data_rvalid_i && !we_q) rdata_q <= ral;
    end
endmodule

// File: tb/tb_lsu_mem_interface.sv
// tb_lsu_mem_interface: directed and randomized transactions against a lane-level reference model
module tb_lsu_mem_interface;
  logic clk = 0, rst_n = 0, valid = 0, we = 0, gnt = 0, rvalid = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic stall, done, mis_o, req, bus_we;
  logic [3:0] bus_be;
  logic [31:0] rdata, bus_addr, bus_wdata;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_rdata = 0;

  always #5 clk = ~clk;

  lsu_mem_interface dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .we_i(we), .size_i(size),
    .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done),
    .misaligned_o(mis_o), .rdata_o(rdata), .data_req_o(req), .data_we_o(bus_we),
    .data_be_o(bus_be), .data_addr_o(bus_addr), .data_wdata_o(bus_wdata),
    .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req"}, {31'h0, req}, 0);
    chk({tag, ".done"}, {31'h0, done}, 0);
    chk({tag, ".mis"}, {31'h0, mis_o}, 0);
    chk({tag, ".stall"}, {31'h0, stall}, 0);
    chk({tag, ".we"}, {31'h0, bus_we}, 0);
    chk({tag, ".be"}, {28'h0, bus_be}, 0);
    chk({tag, ".addr"}, bus_addr, 0);
    chk({tag, ".wdata"}, bus_wdata, 0);
    chk({tag, ".rdata"}, rdata, 0);
  endtask

  // Drives one access and checks every cycle; gd/rd are extra cycles before gnt/rvalid
  task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] resp, input int gd, input int rd);
    logic m;
    int n;
    int off;
    logic [3:0] be;
    logic [31:0] wl;
    logic [7:0] b[4];
    off = int'(a[1:0]);
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    m = sz == 2'd3 || (off % n) != 0;
    be = 0;
    for (int k = 0; k < n; k++) if (off + k < 4) be[off+k] = 1'b1;
    for (int l = 0; l < 4; l++) wl[8*l+:8] = wd[8*(l%n)+:8];
    for (int l = 0; l < 4; l++) b[l] = resp[8*l+:8];
    valid = 1; we = w; size = sz; addr = a; wdata = wd;
    #1 chk("accept.stall", {31'h0, stall}, 1);
    step;
    valid = 0; we = $urandom; size = 2'($urandom); addr = $urandom; wdata = $urandom;
    #1;
    if (m) begin
      chk("mis.done", {31'h0, done}, 1);
      chk("mis.flag", {31'h0, mis_o}, 1);
      chk("mis.req", {31'h0, req}, 0);
      chk("mis.stall", {31'h0, stall}, 0);
      exp_rdata = 0;
      chk("mis.rdata", rdata, exp_rdata);
      step;
      chk("mis.after", {31'h0, done}, 0);
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      chk("req.req", {31'h0, req}, 1);
      chk("req.addr", bus_addr, {a[31:2], 2'b00});
      chk("req.be", {28'h0, bus_be}, {28'h0, be});
      chk("req.we", {31'h0, bus_we}, {31'h0, w});
      if (w) chk("req.wdata", bus_wdata, wl);
      chk("req.stall", {31'h0, stall}, 1);
      chk("req.done", {31'h0, done}, 0);
      gnt = i == gd; rvalid = 1'($urandom); bus_rdata = $urandom;
      step;
      gnt = 0; rvalid = 0;
      #1;
    end
    for (int j = 0; j <= rd; j++) begin
      chk("wait.req", {31'h0, req}, 0);
      chk("wait.stall", {31'h0, stall}, 1);
      chk("wait.done", {31'h0, done}, 0);
      rvalid = j == rd; bus_rdata = j == rd ? resp : $urandom;
      step;
      rvalid = 0;
      #1;
    end
    if (!w) exp_rdata = sz == 2'd0 ? {24'h0, b[off]} : sz == 2'd1 ? {16'h0, b[off+1], b[off]} : resp;
    chk("done.done", {31'h0, done}, 1);
    chk("done.mis", {31'h0, mis_o}, 0);
    chk("done.stall", {31'h0, stall}, 0);
    chk("done.rdata", rdata, exp_rdata);
    step;
    chk("idle.done", {31'h0, done}, 0);
    chk("idle.rdata", rdata, exp_rdata);
  endtask

  initial begin
    @(negedge clk);
    #1 chk_zero("reset");
    rst_n = 1;
    step;
    txn(0, 2'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0);
    txn(0, 2'd0, 32'h103, 0, 32'hAABBCCDD, 0, 0);
    txn(1, 2'd1, 32'h2002, 32'h1234ABCD, 32'h55555555, 0, 0);
    txn(0, 2'd2, 32'h340, 0, 32'h01234567, 3, 0);
    txn(0, 2'd2, 32'h101, 0, 32'hFFFFFFFF, 0, 0);
    txn(0, 2'd1, 32'h102, 0, 32'h87654321, 1, 2);
    // Reset while waiting for the response
    valid = 1; we = 0; size = 2'd2; addr = 32'h400;
    step;
    valid = 0; gnt = 1;
    step;
    gnt = 0;
    rst_n = 0;
    #1 chk_zero("midrst");
    exp_rdata = 0;
    @(negedge clk);
    rst_n = 1; rvalid = 1; bus_rdata = 32'hCAFEF00D;
    step;
    rvalid = 0;
    #1 chk_zero("late_rvalid");
    txn(0, 2'd2, 32'h500, 0, 32'h13579BDF, 0, 0);
    for (int t = 0; t < 150; t++)
      txn(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
